chip_select_router: RTL and testbench

Parametrised successor of the single-bit chip-select decode. It accepts memory requests on a valid/ready port, decodes a configurable address field into a one-hot bank chip-select, and registers the request toward the selected bank. It tracks outstanding reads in order and muxes the matching bank's read data back to the requester. It sits between the HotCache controller and the banked data/tag arrays.

---
 rtl/chip_select_pkg.sv | 21 ++
 rtl/sel_tag_fifo.sv | 57 +++++
 rtl/chip_select_router.sv | 137 +++++++++++++
 tb/tb_chip_select_router.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_select_pkg.sv
// Shared helpers for the chip-select router: width math and the bank index type.
package chip_select_pkg;

  localparam int unsigned MaxSelW = 8;

  // Wide enough for any supported bank count; narrower fields are zero-extended into it.
  typedef logic [MaxSelW-1:0] bank_idx_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned sel_w(input int unsigned num_banks);
    return (num_banks < 2) ? 1 : clog2(num_banks);
  endfunction

endpackage

// File: rtl/sel_tag_fifo.sv
// In-order FIFO of bank indices for outstanding reads; full/empty come from a registered count.
module sel_tag_fifo
  import chip_select_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PtrW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/chip_select_router.sv
// Decodes request addresses to a one-hot bank select, registers the request toward the bank,
// and returns read data strictly in issue order, flagging out-of-order responses as errors.
module chip_select_router
  import chip_select_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_BANKS = 2,
  parameter int unsigned SEL_LSB   = 0,
  parameter int unsigned OUTST     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic                        req_we,
  input  logic [DATA_W-1:0]           req_wdata,
  output logic [NUM_BANKS-1:0]        bank_cs,
  output logic [ADDR_W-1:0]           bank_addr,
  output logic                        bank_we,
  output logic [DATA_W-1:0]           bank_wdata,
  input  logic [NUM_BANKS-1:0]        bank_ready,
  input  logic [NUM_BANKS-1:0]        bank_rvalid,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        err
);

  localparam int unsigned SEL_W = sel_w(NUM_BANKS);

  logic [NUM_BANKS-1:0] cs_q, cs_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 err_q, err_d;
  logic                 init_q;

  logic [SEL_W-1:0]     tag_dout;
  logic                 tag_full, tag_empty, tag_push, tag_pop;
  bank_idx_t            req_sel, head_sel;
  logic [NUM_BANKS-1:0] req_onehot, head_mask;
  logic [DATA_W-1:0]    head_rdata;
  logic                 stage_full, fire, accept, rsp_legal, rsp_illegal;

  assign req_sel  = bank_idx_t'(req_addr[SEL_LSB +: SEL_W]);
  assign head_sel = bank_idx_t'(tag_dout);

  // head_mask stays zero when nothing is outstanding, so any rvalid then counts as illegal.
  always_comb begin
    req_onehot = '0;
    head_mask  = '0;
    head_rdata = '0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      if (req_sel == bank_idx_t'(k)) req_onehot[k] = 1'b1;
      if (!tag_empty && head_sel == bank_idx_t'(k)) begin
        head_mask[k] = 1'b1;
        head_rdata   = bank_rdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign stage_full  = |cs_q;
  assign fire        = |(cs_q & bank_ready);
  assign req_ready   = init_q && (!stage_full || fire) && !tag_full;
  assign accept      = req_valid && req_ready;
  assign tag_push    = accept && !req_we;
  assign rsp_legal   = |(bank_rvalid & head_mask);
  assign rsp_illegal = |(bank_rvalid & ~head_mask);
  assign tag_pop     = rsp_legal;

  always_comb begin
    cs_d    = cs_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    if (accept) begin
      cs_d    = req_onehot;
      addr_d  = req_addr;
      we_d    = req_we;
      wdata_d = req_wdata;
    end else if (fire) begin
      cs_d = '0;
    end
    rsp_valid_d = rsp_legal;
    rsp_rdata_d = rsp_legal ? head_rdata : rsp_rdata_q;
    err_d       = err_q | rsp_illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q        <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      cs_q        <= cs_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
      init_q      <= 1'b1;
    end
  end

  sel_tag_fifo #(
    .WIDTH (SEL_W),
    .DEPTH (OUTST)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (req_addr[SEL_LSB +: SEL_W]),
    .dout  (tag_dout),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign bank_cs    = cs_q;
  assign bank_addr  = addr_q;
  assign bank_we    = we_q;
  assign bank_wdata = wdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign err        = err_q;

endmodule

// File: tb/tb_chip_select_router.sv
// Directed bench for chip_select_router with 4 banks, bank field at addr[3:2], 4 outstanding reads.
module tb_chip_select_router;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic        req_we;
  logic [7:0]  req_wdata;
  logic [3:0]  bank_cs;
  logic [7:0]  bank_addr;
  logic        bank_we;
  logic [7:0]  bank_wdata;
  logic [3:0]  bank_ready;
  logic [3:0]  bank_rvalid;
  logic [31:0] bank_rdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  chip_select_router #(
    .ADDR_W    (8),
    .DATA_W    (8),
    .NUM_BANKS (4),
    .SEL_LSB   (2),
    .OUTST     (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_we      (req_we),
    .req_wdata   (req_wdata),
    .bank_cs     (bank_cs),
    .bank_addr   (bank_addr),
    .bank_we     (bank_we),
    .bank_wdata  (bank_wdata),
    .bank_ready  (bank_ready),
    .bank_rvalid (bank_rvalid),
    .bank_rdata  (bank_rdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [7:0] a, input logic we, input logic [7:0] wd);
    req_valid = v;
    req_addr  = a;
    req_we    = we;
    req_wdata = wd;
  endtask

  task automatic respond(input int k, input logic [7:0] d);
    bank_rvalid         = 4'b0001 << k;
    bank_rdata[k*8 +: 8] = d;
  endtask

  initial begin
    rst_n       = 1'b0;
    bank_ready  = 4'b0;
    bank_rvalid = 4'b0;
    bank_rdata  = 32'h0;
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    #22;
    check_eq("rst_req_ready", {31'b0, req_ready}, 0);
    check_eq("rst_bank_cs", {28'b0, bank_cs}, 0);
    check_eq("rst_bank_addr", {24'b0, bank_addr}, 0);
    check_eq("rst_bank_we", {31'b0, bank_we}, 0);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check_eq("rst_rsp_rdata", {24'b0, rsp_rdata}, 0);
    check_eq("rst_err", {31'b0, err}, 0);
    #1 rst_n = 1'b1;
    tick();
    check_eq("rel_req_ready", {31'b0, req_ready}, 1);
    check_eq("rel_bank_cs", {28'b0, bank_cs}, 0);

    // Decode: read at 0x0C selects bank 3
    set_req(1'b1, 8'h0C, 1'b0, 8'h00);
    tick();
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    check_eq("dec_cs", {28'b0, bank_cs}, 32'h8);
    check_eq("dec_addr", {24'b0, bank_addr}, 32'h0C);
    check_eq("dec_we", {31'b0, bank_we}, 0);
    bank_ready = 4'b1000;
    tick();
    bank_ready = 4'b0000;
    check_eq("dec_fired_cs", {28'b0, bank_cs}, 0);
    respond(3, 8'hA5);
    tick();
    bank_rvalid = 4'b0;
    check_eq("dec_rsp_valid", {31'b0, rsp_valid}, 1);
    check_eq("dec_rsp_rdata", {24'b0, rsp_rdata}, 32'hA5);
    tick();
    check_eq("dec_rsp_pulse", {31'b0, rsp_valid}, 0);

    // Backpressure: write to bank 1 stalls 3 cycles while a read waits
    set_req(1'b1, 8'h04, 1'b1, 8'h3C);
    tick();
    set_req(1'b1, 8'h14, 1'b0, 8'h00);
    #1;
    check_eq("bp_ready_0", {31'b0, req_ready}, 0);
    check_eq("bp_cs", {28'b0, bank_cs}, 32'h2);
    check_eq("bp_wdata", {24'b0, bank_wdata}, 32'h3C);
    for (int i = 1; i < 3; i++) begin
      tick();
      check_eq("bp_addr_hold", {24'b0, bank_addr}, 32'h04);
      check_eq("bp_ready_hold", {31'b0, req_ready}, 0);
    end
    tick();
    bank_ready = 4'b0010;
    #1;
    check_eq("bp_ready_fire", {31'b0, req_ready}, 1);
    tick();
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    check_eq("bp_second_cs", {28'b0, bank_cs}, 32'h2);
    check_eq("bp_second_addr", {24'b0, bank_addr}, 32'h14);
    check_eq("bp_second_we", {31'b0, bank_we}, 0);
    tick();
    check_eq("bp_drained", {28'b0, bank_cs}, 0);
    respond(1, 8'h77);
    tick();
    bank_rvalid = 4'b0;
    check_eq("bp_rsp_valid", {31'b0, rsp_valid}, 1);
    check_eq("bp_rsp_rdata", {24'b0, rsp_rdata}, 32'h77);

    // Tag full: four reads to bank 0 fill the FIFO
    bank_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 8'(i * 16), 1'b0, 8'h00);
      tick();
    end
    set_req(1'b1, 8'h40, 1'b0, 8'h00);
    #1;
    check_eq("full_ready", {31'b0, req_ready}, 0);
    respond(0, 8'h11);
    #1;
    check_eq("full_no_comb_path", {31'b0, req_ready}, 0);
    tick();
    bank_rvalid = 4'b0;
    check_eq("full_rsp_valid", {31'b0, rsp_valid}, 1);
    check_eq("full_rsp_rdata", {24'b0, rsp_rdata}, 32'h11);
    check_eq("full_ready_after_pop", {31'b0, req_ready}, 1);
    tick();
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    #1;
    check_eq("full_again", {31'b0, req_ready}, 0);
    for (int i = 0; i < 4; i++) begin
      respond(0, 8'(8'h21 + i));
      tick();
      check_eq("full_drain_rdata", {24'b0, rsp_rdata}, 32'(8'h21 + i));
    end
    bank_rvalid = 4'b0;

    // Ordering: bank 0 then bank 1; bank 1 answering first is an error
    set_req(1'b1, 8'h00, 1'b0, 8'h00);
    tick();
    set_req(1'b1, 8'h04, 1'b0, 8'h00);
    tick();
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    respond(1, 8'h99);
    tick();
    bank_rvalid = 4'b0;
    check_eq("ord_err", {31'b0, err}, 1);
    check_eq("ord_no_rsp", {31'b0, rsp_valid}, 0);
    respond(0, 8'h42);
    tick();
    check_eq("ord_head_valid", {31'b0, rsp_valid}, 1);
    check_eq("ord_head_rdata", {24'b0, rsp_rdata}, 32'h42);
    respond(1, 8'h55);
    tick();
    bank_rvalid = 4'b0;
    check_eq("ord_second_rdata", {24'b0, rsp_rdata}, 32'h55);
    check_eq("ord_err_sticky", {31'b0, err}, 1);

    // Push and pop together keep the count at 3
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 8'h08, 1'b0, 8'h00);
      tick();
    end
    respond(2, 8'h61);
    #1;
    check_eq("pp_ready_cnt3", {31'b0, req_ready}, 1);
    tick();
    bank_rvalid = 4'b0;
    check_eq("pp_rsp_rdata", {24'b0, rsp_rdata}, 32'h61);
    #1;
    check_eq("pp_ready_still", {31'b0, req_ready}, 1);
    tick();
    check_eq("pp_full_now", {31'b0, req_ready}, 0);
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      respond(2, 8'(8'h62 + i));
      tick();
      check_eq("pp_drain_rdata", {24'b0, rsp_rdata}, 32'(8'h62 + i));
    end
    bank_rvalid = 4'b0;

    // Writes produce no response
    set_req(1'b1, 8'h0C, 1'b1, 8'hEE);
    tick();
    check_eq("wr_cs", {28'b0, bank_cs}, 32'h8);
    check_eq("wr_we", {31'b0, bank_we}, 1);
    check_eq("wr_no_rsp0", {31'b0, rsp_valid}, 0);
    set_req(1'b1, 8'h00, 1'b1, 8'h12);
    tick();
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    check_eq("wr_wdata", {24'b0, bank_wdata}, 32'h12);
    check_eq("wr_no_rsp1", {31'b0, rsp_valid}, 0);
    tick();
    check_eq("wr_no_rsp2", {31'b0, rsp_valid}, 0);
    check_eq("wr_idle", {28'b0, bank_cs}, 0);

    // Reset mid-transaction drops the outstanding read
    set_req(1'b1, 8'h04, 1'b0, 8'h00);
    tick();
    set_req(1'b0, 8'h00, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_err", {31'b0, err}, 0);
    check_eq("mid_rst_cs", {28'b0, bank_cs}, 0);
    check_eq("mid_rst_ready", {31'b0, req_ready}, 0);
    #2 rst_n = 1'b1;
    tick();
    respond(1, 8'h33);
    tick();
    bank_rvalid = 4'b0;
    check_eq("late_rsp_err", {31'b0, err}, 1);
    check_eq("late_rsp_dropped", {31'b0, rsp_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
